// File: rtl/ep_lookup_pkg.sv
// ---------------------------------------------------------------------------
// ep_lookup_pkg
// Shared definitions for the IP->MAC endpoint resolver:
//   - entry field offsets, expressed as functions of the BRAM word width so
//     that any width >= 160 bits lays out the same way (MSB-first);
//   - the lookup FSM state encoding;
//   - ep_hash(), the XOR-fold hash from a 32-bit IP to a table index.
// No ports (package only).
// ---------------------------------------------------------------------------
package ep_lookup_pkg;

  // Lookup controller states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_RESP
  } ep_state_e;

  // Entry layout, MSB-first: valid flag, 31 ignored bits, IP, dst MAC,
  // src MAC, then any remaining low bits are ignored.
  function automatic int ep_valid_bit(input int w);
    return w - 1;
  endfunction

  function automatic int ep_ip_msb(input int w);
    return w - 33;
  endfunction

  function automatic int ep_ip_lsb(input int w);
    return w - 64;
  endfunction

  function automatic int ep_dmac_msb(input int w);
    return w - 65;
  endfunction

  function automatic int ep_dmac_lsb(input int w);
    return w - 112;
  endfunction

  function automatic int ep_smac_msb(input int w);
    return w - 113;
  endfunction

  function automatic int ep_smac_lsb(input int w);
    return w - 160;
  endfunction

  // XOR-fold of the IP into aw-bit chunks. Bit i of the IP lands in bit
  // (i mod aw) of the result, which is the same as zero-padding the IP to a
  // multiple of aw and XORing the chunks together. Only the low aw bits of
  // the return value are meaningful.
  function automatic logic [15:0] ep_hash(input logic [31:0] ip, input int aw);
    logic [15:0] h;
    h = '0;
    for (int i = 0; i < 32; i++) begin
      h[4'(i % aw)] = h[4'(i % aw)] ^ ip[i];
    end
    return h;
  endfunction

endpackage

// File: rtl/ep_entry_decode.sv
// ---------------------------------------------------------------------------
// ep_entry_decode
// Purely combinational slice of one endpoint-table word into its fields.
// Shared with the table writer so both sides agree on the layout.
// Ports:
//   entry    in  W   raw table word
//   valid    out 1   entry holds a live endpoint
//   ip       out 32  endpoint IP address
//   dst_mac  out 48  destination MAC
//   src_mac  out 48  source MAC
// ---------------------------------------------------------------------------
module ep_entry_decode
  import ep_lookup_pkg::*;
#(
  parameter int W = 256
) (
  input  logic [W-1:0] entry,
  output logic         valid,
  output logic [31:0]  ip,
  output logic [47:0]  dst_mac,
  output logic [47:0]  src_mac
);

  localparam int VB       = ep_valid_bit(W);
  localparam int IP_MSB   = ep_ip_msb(W);
  localparam int IP_LSB   = ep_ip_lsb(W);
  localparam int DMAC_MSB = ep_dmac_msb(W);
  localparam int DMAC_LSB = ep_dmac_lsb(W);
  localparam int SMAC_MSB = ep_smac_msb(W);
  localparam int SMAC_LSB = ep_smac_lsb(W);

  assign valid   = entry[VB];
  assign ip      = entry[IP_MSB:IP_LSB];
  assign dst_mac = entry[DMAC_MSB:DMAC_LSB];
  assign src_mac = entry[SMAC_MSB:SMAC_LSB];

  // The gap between the valid flag and the IP, and any bits below the src
  // MAC, carry no meaning for lookups.
  logic unused_gap;
  assign unused_gap = ^entry[VB-1:IP_MSB+1];

  generate
    if (W > 160) begin : g_tail
      logic unused_tail;
      assign unused_tail = ^entry[SMAC_LSB-1:0];
    end
  endgenerate

endmodule

// File: rtl/endpoint_lookup_probe.sv
// ---------------------------------------------------------------------------
// endpoint_lookup_probe
// Resolves a destination IP to its MAC pair by hashing into a BRAM endpoint
// table and linearly probing up to MAX_PROBES consecutive slots (wrapping at
// the end of the table). One lookup is in flight at a time.
//
// Optional feature macro: LOOKUP_STATS_EN
//   When defined, adds saturating 32-bit hit/miss/error counters that step
//   on each result handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   dst_ip/lookup_valid/lookup_ready   request handshake (ready only in IDLE)
//   result_valid/result_ready          result handshake (held until ready)
//   lookup_hit, lookup_error, dst_mac, src_mac, probe_count   result fields
//   bram_addr_b, bram_en_b, bram_dout_b  read-only BRAM port
//   stat_hits, stat_misses, stat_errors  (LOOKUP_STATS_EN only)
// ---------------------------------------------------------------------------
module endpoint_lookup_probe
  import ep_lookup_pkg::*;
#(
  parameter int ADDR_WIDTH      = 4,
  parameter int BRAM_DATA_WIDTH = 256,
  parameter int RD_LATENCY      = 1,
  parameter int MAX_PROBES      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                dst_ip,
  input  logic                       lookup_valid,
  output logic                       lookup_ready,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic                       lookup_hit,
  output logic                       lookup_error,
  output logic [47:0]                dst_mac,
  output logic [47:0]                src_mac,
  output logic [ADDR_WIDTH:0]        probe_count,
  output logic [ADDR_WIDTH-1:0]      bram_addr_b,
  output logic                       bram_en_b,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_dout_b
`ifdef LOOKUP_STATS_EN
  ,
  output logic [31:0]                stat_hits,
  output logic [31:0]                stat_misses,
  output logic [31:0]                stat_errors
`endif
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] PROBE_LIMIT = CW'(MAX_PROBES);
  // Last value of the wait counter before the read data is due; only
  // reachable when the BRAM has more than one cycle of latency.
  localparam logic [1:0] WAIT_LAST = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

  ep_state_e             state_q, state_d;
  logic [31:0]           ip_q, ip_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [CW-1:0]         probe_q, probe_d;
  logic [1:0]            wait_q, wait_d;
  logic                  result_valid_q, result_valid_d;
  logic                  hit_q, hit_d;
  logic                  error_q, error_d;
  logic [47:0]           dmac_q, dmac_d;
  logic [47:0]           smac_q, smac_d;
  logic [CW-1:0]         count_q, count_d;

  logic        ent_valid;
  logic [31:0] ent_ip;
  logic [47:0] ent_dmac;
  logic [47:0] ent_smac;

  ep_entry_decode #(
    .W(BRAM_DATA_WIDTH)
  ) u_decode (
    .entry  (bram_dout_b),
    .valid  (ent_valid),
    .ip     (ent_ip),
    .dst_mac(ent_dmac),
    .src_mac(ent_smac)
  );

  // Next-state logic for the probe controller. The result fields are only
  // rewritten when a CHECK reaches a decision, so after a result transfer
  // they keep showing the last answer until the next one is ready.
  always_comb begin
    state_d        = state_q;
    ip_d           = ip_q;
    idx_d          = idx_q;
    probe_d        = probe_q;
    wait_d         = wait_q;
    result_valid_d = result_valid_q;
    hit_d          = hit_q;
    error_d        = error_q;
    dmac_d         = dmac_q;
    smac_d         = smac_q;
    count_d        = count_q;

    case (state_q)
      ST_IDLE: begin
        if (lookup_valid) begin
          ip_d    = dst_ip;
          idx_d   = ADDR_WIDTH'(ep_hash(dst_ip, ADDR_WIDTH));
          probe_d = CW'(1);
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        wait_d  = 2'd0;
        state_d = (RD_LATENCY > 1) ? ST_WAIT : ST_CHECK;
      end

      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_CHECK;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      ST_CHECK: begin
        if (ent_valid && (ent_ip == ip_q)) begin
          hit_d          = 1'b1;
          error_d        = 1'b0;
          dmac_d         = ent_dmac;
          smac_d         = ent_smac;
          count_d        = probe_q;
          result_valid_d = 1'b1;
          state_d        = ST_RESP;
        end else if (!ent_valid || (probe_q == PROBE_LIMIT)) begin
          // An empty slot ends the chain as a miss; a full run of
          // occupied, non-matching slots is reported as an error.
          hit_d          = 1'b0;
          error_d        = ent_valid;
          dmac_d         = '0;
          smac_d         = '0;
          count_d        = probe_q;
          result_valid_d = 1'b1;
          state_d        = ST_RESP;
        end else begin
          idx_d   = idx_q + 1'b1;
          probe_d = probe_q + 1'b1;
          state_d = ST_ISSUE;
        end
      end

      ST_RESP: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller registers. Reset drops any lookup or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ip_q           <= '0;
      idx_q          <= '0;
      probe_q        <= '0;
      wait_q         <= '0;
      result_valid_q <= 1'b0;
      hit_q          <= 1'b0;
      error_q        <= 1'b0;
      dmac_q         <= '0;
      smac_q         <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      ip_q           <= ip_d;
      idx_q          <= idx_d;
      probe_q        <= probe_d;
      wait_q         <= wait_d;
      result_valid_q <= result_valid_d;
      hit_q          <= hit_d;
      error_q        <= error_d;
      dmac_q         <= dmac_d;
      smac_q         <= smac_d;
      count_q        <= count_d;
    end
  end

  // The read strobe is a decode of the registered state, so it is high for
  // exactly the one ISSUE cycle of each probe.
  assign lookup_ready = (state_q == ST_IDLE);
  assign bram_en_b    = (state_q == ST_ISSUE);
  assign bram_addr_b  = idx_q;
  assign result_valid = result_valid_q;
  assign lookup_hit   = hit_q;
  assign lookup_error = error_q;
  assign dst_mac      = dmac_q;
  assign src_mac      = smac_q;
  assign probe_count  = count_q;

`ifdef LOOKUP_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [31:0] misses_q, misses_d;
  logic [31:0] errors_q, errors_d;
  logic        xfer;

  assign xfer = (state_q == ST_RESP) && result_ready;

  // Outcome counters step once per delivered result and stick at all-ones.
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    errors_d = errors_q;
    if (xfer) begin
      if (hit_q) begin
        if (hits_q != '1) hits_d = hits_q + 32'd1;
      end else if (error_q) begin
        if (errors_q != '1) errors_d = errors_q + 32'd1;
      end else begin
        if (misses_q != '1) misses_d = misses_q + 32'd1;
      end
    end
  end

  // Counter registers, cleared with the rest of the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      errors_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
      errors_q <= errors_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_errors = errors_q;
`endif

endmodule
